flag_shadow_stack: RTL and testbench

Parametrised processor status-flag register with a nested-interrupt shadow stack. It holds NFLAGS flag bits (bit 0 = C, bit 1 = Z by convention), each with its own load, set and clear controls. It also holds a DEPTH-entry LIFO of saved flag words. Interrupt entry saves the flags (push) and RETI/RETIE restores them (pop), which allows interrupts to nest up to DEPTH levels. It sits between the ALU flag outputs and the control unit / branch logic.

---
 rtl/flag_shadow_stack.sv | 107 ++++++++++
 tb/tb_flag_shadow_stack.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/flag_shadow_stack.sv
// Status-flag register with per-bit load/set/clear and a LIFO shadow stack
// that saves/restores the whole flag word across nested interrupts.
module flag_shadow_stack #(
  parameter int NFLAGS = 2,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NFLAGS-1:0]          flg_in,
  input  logic [NFLAGS-1:0]          flg_ld,
  input  logic [NFLAGS-1:0]          flg_set,
  input  logic [NFLAGS-1:0]          flg_clr,
  input  logic                       shad_push,
  input  logic                       shad_pop,
  input  logic                       err_clr,
  output logic [NFLAGS-1:0]          flags,
  output logic [$clog2(DEPTH+1)-1:0] depth,
  output logic                       full,
  output logic                       empty,
  output logic                       ovf,
  output logic                       unf
);

  localparam int DW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [NFLAGS-1:0] flags_q, flags_d;
  logic [DW-1:0]     depth_q, depth_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic [NFLAGS-1:0] mem_q [DEPTH];

  logic          full_w, empty_w;
  logic          pop_ok, swap, push_ok;
  logic          ovf_ev, unf_ev;
  logic          wr_en;
  logic [AW-1:0] top_idx, wr_idx;

  assign full_w  = (depth_q == DW'(DEPTH));
  assign empty_w = (depth_q == '0);

  // A pop is only honoured with something on the stack; push+pop on a
  // non-empty stack is a swap of the top entry and never overflows.
  assign pop_ok  = shad_pop && !empty_w;
  assign swap    = shad_push && pop_ok;
  assign push_ok = shad_push && !pop_ok && !full_w;
  assign ovf_ev  = shad_push && !pop_ok && full_w;
  assign unf_ev  = shad_pop && empty_w && !shad_push;

  assign top_idx = AW'(depth_q - DW'(1));
  assign wr_idx  = swap ? top_idx : AW'(depth_q);
  assign wr_en   = swap || push_ok;

  always_comb begin
    flags_d = flags_q;
    for (int i = 0; i < NFLAGS; i++) begin
      if (flg_clr[i])      flags_d[i] = 1'b0;
      else if (flg_set[i]) flags_d[i] = 1'b1;
      else if (flg_ld[i])  flags_d[i] = flg_in[i];
    end
    if (pop_ok) flags_d = mem_q[top_idx];
  end

  always_comb begin
    depth_d = depth_q;
    if (push_ok)              depth_d = depth_q + DW'(1);
    else if (pop_ok && !swap) depth_d = depth_q - DW'(1);
  end

  always_comb begin
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (err_clr) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
    if (ovf_ev) ovf_d = 1'b1;
    if (unf_ev) unf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flags_q <= '0;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      flags_q <= flags_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Stack storage is deliberately not reset; reads are guarded by depth.
  always_ff @(posedge clk) begin
    if (rst_n && wr_en) mem_q[wr_idx] <= flags_q;
  end

  assign flags = flags_q;
  assign depth = depth_q;
  assign full  = full_w;
  assign empty = empty_w;
  assign ovf   = ovf_q;
  assign unf   = unf_q;

endmodule

// File: tb/tb_flag_shadow_stack.sv
// Self-checking bench: queue-based stack model checked every cycle, plus
// hand-computed directed expectations.
module tb_flag_shadow_stack;

  localparam int NF  = 2;
  localparam int DEP = 4;
  localparam int DW  = $clog2(DEP + 1);

  logic          clk;
  logic          rst_n;
  logic [NF-1:0] flg_in, flg_ld, flg_set, flg_clr;
  logic          shad_push, shad_pop, err_clr;
  logic [NF-1:0] flags;
  logic [DW-1:0] depth;
  logic          full, empty, ovf, unf;

  flag_shadow_stack #(.NFLAGS(NF), .DEPTH(DEP)) dut (
    .clk(clk), .rst_n(rst_n),
    .flg_in(flg_in), .flg_ld(flg_ld), .flg_set(flg_set), .flg_clr(flg_clr),
    .shad_push(shad_push), .shad_pop(shad_pop), .err_clr(err_clr),
    .flags(flags), .depth(depth), .full(full), .empty(empty),
    .ovf(ovf), .unf(unf)
  );

  // clock/reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_pass  = 0;
  int n_total = 0;

  // scoreboard / model state
  logic [NF-1:0] exp_q[$];
  logic [NF-1:0] m_flags = '0;
  logic          m_ovf   = 1'b0;
  logic          m_unf   = 1'b0;
  bit            model_on = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Model advances once per rising edge using the inputs held across it.
  task automatic model_step();
    logic [NF-1:0] nf;
    logic [NF-1:0] old;
    bit have_top;
    old = m_flags;
    have_top = (exp_q.size() > 0);
    if (!rst_n) begin
      exp_q.delete();
      m_flags = '0;
      m_ovf = 1'b0;
      m_unf = 1'b0;
      return;
    end
    nf = old;
    for (int i = 0; i < NF; i++) begin
      if (flg_clr[i])      nf[i] = 1'b0;
      else if (flg_set[i]) nf[i] = 1'b1;
      else if (flg_ld[i])  nf[i] = flg_in[i];
    end
    if (err_clr) begin
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end
    if (shad_pop && have_top) begin
      nf = exp_q[exp_q.size()-1];
      if (shad_push) exp_q[exp_q.size()-1] = old;
      else void'(exp_q.pop_back());
    end else if (shad_push) begin
      if (exp_q.size() < DEP) exp_q.push_back(old);
      else m_ovf = 1'b1;
    end else if (shad_pop) begin
      m_unf = 1'b1;
    end
    m_flags = nf;
  endtask

  // driver task: hold inputs across one rising edge, return 1 time unit after
  task automatic drive(input logic rn, input logic [NF-1:0] ld, input logic [NF-1:0] din,
                       input logic [NF-1:0] st, input logic [NF-1:0] cl,
                       input logic pu, input logic po, input logic ec);
    rst_n = rn; flg_ld = ld; flg_in = din; flg_set = st; flg_clr = cl;
    shad_push = pu; shad_pop = po; err_clr = ec;
    @(posedge clk);
    model_step();
    model_on = 1'b1;
    #1;
  endtask

  task automatic idle();
    drive(1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
  endtask

  // every-cycle compare against the model
  always @(negedge clk) begin
    if (model_on) begin
      chk("m_flags", int'(flags), int'(m_flags));
      chk("m_depth", int'(depth), exp_q.size());
      chk("m_full",  int'(full),  int'(exp_q.size() == DEP));
      chk("m_empty", int'(empty), int'(exp_q.size() == 0));
      chk("m_ovf",   int'(ovf),   int'(m_ovf));
      chk("m_unf",   int'(unf),   int'(m_unf));
    end
  end

  initial begin
    // reset for two cycles
    drive(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    chk("rst_flags", int'(flags), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_depth", int'(depth), 0);
    chk("rst_full",  int'(full), 0);
    drive(1'b1, 2'b01, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    chk("ld_bit0", int'(flags), 1);

    // priority clr > set > ld
    drive(1'b1, 2'b00, 2'b00, 2'b00, 2'b11, 1'b0, 1'b0, 1'b0);
    chk("clr_all", int'(flags), 0);
    drive(1'b1, 2'b11, 2'b11, 2'b10, 2'b01, 1'b0, 1'b0, 1'b0);
    chk("prio", int'(flags), 2);
    drive(1'b1, 2'b00, 2'b00, 2'b00, 2'b11, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
    chk("push00_depth", int'(depth), 1);
    drive(1'b1, 2'b11, 2'b11, 2'b10, 2'b01, 1'b0, 1'b1, 1'b0);
    chk("prio_pop", int'(flags), 0);
    chk("prio_pop_empty", int'(empty), 1);

    // nesting to full, then overflow, then unwind
    drive(1'b1, 2'b11, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 2'b11, 2'b10, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 2'b11, 2'b11, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 2'b11, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
    chk("nest_depth", int'(depth), 4);
    chk("nest_full", int'(full), 1);
    drive(1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
    chk("ovf_set", int'(ovf), 1);
    chk("ovf_depth", int'(depth), 4);
    drive(1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
    chk("pop1", int'(flags), 0);
    drive(1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
    chk("pop2", int'(flags), 3);
    drive(1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
    chk("pop3", int'(flags), 2);
    drive(1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
    chk("pop4", int'(flags), 1);
    chk("pop4_empty", int'(empty), 1);

    // underflow and sticky clear
    drive(1'b1, 2'b11, 2'b10, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
    chk("unf_flags", int'(flags), 2);
    chk("unf_set", int'(unf), 1);
    drive(1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1);
    chk("unf_clr", int'(unf), 0);
    chk("ovf_clr", int'(ovf), 0);
    drive(1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1);
    chk("unf_wins", int'(unf), 1);
    drive(1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b1, 1'b1);
    chk("pushpop_empty_depth", int'(depth), 1);
    chk("pushpop_empty_unf", int'(unf), 0);
    drive(1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0);

    // swap
    drive(1'b1, 2'b11, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 2'b11, 2'b10, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
    chk("swap_pre_flags", int'(flags), 2);
    drive(1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0);
    chk("swap_flags", int'(flags), 1);
    chk("swap_depth", int'(depth), 1);
    drive(1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
    chk("swap_pop", int'(flags), 2);
    chk("swap_empty", int'(empty), 1);

    // reset mid-nesting
    drive(1'b1, 2'b00, 2'b00, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) drive(1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
    chk("mid_depth", int'(depth), 3);
    chk("mid_ovf", int'(ovf), 1);
    drive(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
    chk("rst2_depth", int'(depth), 0);
    chk("rst2_flags", int'(flags), 0);
    chk("rst2_ovf", int'(ovf), 0);
    drive(1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
    chk("rst2_unf", int'(unf), 1);

    // mixed traffic, checked by the model only
    for (int i = 0; i < 200; i++) begin
      drive(($urandom_range(0, 29) != 0),
            NF'($urandom_range(0, 3)), NF'($urandom_range(0, 3)),
            NF'($urandom_range(0, 3) == 0 ? $urandom_range(0, 3) : 0),
            NF'($urandom_range(0, 3) == 0 ? $urandom_range(0, 3) : 0),
            ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 7) == 0));
    end
    idle();
    @(negedge clk);
    #1;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
